// File: rtl/turn_sequencer.sv
// turn_sequencer: turns a raw, bouncing player button and move switches into
// one clean enter/move handshake per accepted turn for the game core. It also
// keeps turn, win and loss tallies.
//
// Ports
//   clock, reset_n    system clock (rising edge); asynchronous active-low reset
//   btn_i             raw player button (asynchronous, bouncing)
//   move_sw_i[2:0]    raw player move switches
//   game_ready_i      game core is waiting for a move
//   game_gameover_i   game core game-over flag
//   game_lostwon_i    game core result, 1 = won
//   enter_o           enter strobe to the game core (registered)
//   move_o[2:0]       move value; changes only on entry to DRIVE
//   turn_count_o[4:0] accepted turns in the current game (saturates at 31)
//   wins_o/losses_o   games won / lost (saturate at 15)
//   reject_o          one-cycle pulse: move refused or not acknowledged
//   auto_move_o       one-cycle pulse: timeout move issued
//
// Build option: define TURN_TIMEOUT_EN to enable the ARMED idle timeout, which
// issues move 1 after TIMEOUT_CYCLES cycles without a press. Without it there
// is no timeout counter and auto_move_o is tied to 0.
module turn_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACK_CYCLES      = 8,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_i,
    input  logic [2:0] move_sw_i,
    input  logic       game_ready_i,
    input  logic       game_gameover_i,
    input  logic       game_lostwon_i,
    output logic       enter_o,
    output logic [2:0] move_o,
    output logic [4:0] turn_count_o,
    output logic [3:0] wins_o,
    output logic [3:0] losses_o,
    output logic       reject_o,
    output logic       auto_move_o
);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AKW = $clog2(ACK_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_RDY = 2'd0,
        ARMED    = 2'd1,
        DRIVE    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state_q;
    logic             btn_s1_q, btn_s2_q;
    logic [2:0]       mv_s1_q, mv_s2_q;
    logic             db_lvl_q;
    logic [DBW-1:0]   db_cnt_q;
    logic             go_q;
    logic [AKW-1:0]   ack_q;
    logic             enter_q, reject_q;
    logic [2:0]       move_q;
    logic [4:0]       tc_q;
    logic [3:0]       wins_q, losses_q;
    logic             db_flip, press, mv_ok, go_rise, tc_inc;

    // The debounced level flips on the last of DEBOUNCE_CYCLES consecutive
    // synchronized samples that disagree with it; a press is a 0->1 flip.
    assign db_flip = (btn_s2_q != db_lvl_q) && (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1));
    assign press   = db_flip && btn_s2_q;
    assign mv_ok   = (mv_s2_q != 3'd0) && (mv_s2_q <= 3'd5);
    assign go_rise = game_gameover_i && !go_q;
    assign tc_inc  = (state_q == DRIVE) && !game_ready_i;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            btn_s1_q <= 1'b0;
            btn_s2_q <= 1'b0;
            mv_s1_q  <= 3'd0;
            mv_s2_q  <= 3'd0;
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
            go_q     <= 1'b0;
        end else begin
            btn_s1_q <= btn_i;
            btn_s2_q <= btn_s1_q;
            mv_s1_q  <= move_sw_i;
            mv_s2_q  <= mv_s1_q;
            go_q     <= game_gameover_i;
            if (btn_s2_q == db_lvl_q) begin
                db_cnt_q <= '0;
            end else if (db_flip) begin
                db_lvl_q <= btn_s2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    logic          auto_q;
    assign auto_move_o = auto_q;
`else
    assign auto_move_o = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_RDY;
            enter_q  <= 1'b0;
            move_q   <= 3'd0;
            ack_q    <= '0;
            reject_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            tmo_q    <= '0;
            auto_q   <= 1'b0;
`endif
        end else begin
            reject_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            auto_q   <= 1'b0;
            // Holding the count at 0 outside ARMED restarts it on every entry.
            if (state_q != ARMED) tmo_q <= '0;
`endif
            case (state_q)
                WAIT_RDY: begin
                    enter_q <= 1'b0;
                    if (game_ready_i) state_q <= ARMED;
                end
                ARMED: begin
                    if (press) begin
`ifdef TURN_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                        if (mv_ok) begin
                            move_q  <= mv_s2_q;
                            enter_q <= 1'b1;
                            ack_q   <= '0;
                            state_q <= DRIVE;
                        end else begin
                            reject_q <= 1'b1;
                        end
                    end
`ifdef TURN_TIMEOUT_EN
                    else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        move_q  <= 3'd1;
                        auto_q  <= 1'b1;
                        enter_q <= 1'b1;
                        ack_q   <= '0;
                        state_q <= DRIVE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                DRIVE: begin
                    if (!game_ready_i) begin
                        enter_q <= 1'b0;
                        state_q <= RELEASE;
                    end else if (ack_q == AKW'(ACK_CYCLES - 1)) begin
                        // Core never took the move: give up, count nothing.
                        enter_q  <= 1'b0;
                        reject_q <= 1'b1;
                        state_q  <= RELEASE;
                    end else begin
                        ack_q <= ack_q + 1'b1;
                    end
                end
                RELEASE: begin
                    enter_q <= 1'b0;
                    if (game_ready_i) state_q <= ARMED;
                end
                default: state_q <= WAIT_RDY;
            endcase
        end
    end

    // Game-over clear wins over a same-cycle turn acknowledge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tc_q     <= 5'd0;
            wins_q   <= 4'd0;
            losses_q <= 4'd0;
        end else if (go_rise) begin
            tc_q <= 5'd0;
            if (game_lostwon_i) begin
                if (wins_q != 4'd15) wins_q <= wins_q + 1'b1;
            end else begin
                if (losses_q != 4'd15) losses_q <= losses_q + 1'b1;
            end
        end else if (tc_inc && tc_q != 5'd31) begin
            tc_q <= tc_q + 1'b1;
        end
    end

    assign enter_o      = enter_q;
    assign move_o       = move_q;
    assign turn_count_o = tc_q;
    assign wins_o       = wins_q;
    assign losses_o     = losses_q;
    assign reject_o     = reject_q;
endmodule

// File: tb/tb_turn_sequencer.sv
module tb_turn_sequencer;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       btn;
    logic [2:0] move_sw;
    logic       game_ready, game_gameover, game_lostwon;
    logic       enter, reject, auto_move;
    logic [2:0] move;
    logic [4:0] turn_count;
    logic [3:0] wins, losses;

    int err_cnt = 0;
    int chk_cnt = 0;
    int enter_rises = 0;
    int en_hi = 0;
    int rej_cnt = 0;
    logic enter_prev = 1'b0;

    always #5 clock = ~clock;

    turn_sequencer #(.DEBOUNCE_CYCLES(4), .ACK_CYCLES(8), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .reset_n(reset_n), .btn_i(btn), .move_sw_i(move_sw),
        .game_ready_i(game_ready), .game_gameover_i(game_gameover),
        .game_lostwon_i(game_lostwon), .enter_o(enter), .move_o(move),
        .turn_count_o(turn_count), .wins_o(wins), .losses_o(losses),
        .reject_o(reject), .auto_move_o(auto_move));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock, observed 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (enter && !enter_prev) enter_rises++;
            if (enter) en_hi++;
            if (reject) rej_cnt++;
            enter_prev = enter;
        end
    endtask

    task automatic wait_enter();
        for (int i = 0; i < 20 && !enter; i++) tick();
        chk("enter_wait", enter, 1);
    endtask

    // Accepted turn: press, acknowledge by dropping ready, then re-arm.
    task automatic do_turn(input logic [2:0] mv);
        move_sw = mv;
        btn = 1'b1;
        wait_enter();
        game_ready = 1'b0;
        tick();
        btn = 1'b0;
        game_ready = 1'b1;
        tick(8);
    endtask

    initial begin
        logic [2:0] bad_mv [3];
        bad_mv[0] = 3'd6; bad_mv[1] = 3'd0; bad_mv[2] = 3'd7;
        reset_n = 1'b0; btn = 1'b0; move_sw = 3'd0;
        game_ready = 1'b0; game_gameover = 1'b0; game_lostwon = 1'b0;
        #22;
        chk("rst_enter", enter, 0);
        chk("rst_move", move, 0);
        chk("rst_tc", turn_count, 0);
        chk("rst_wins", wins, 0);
        chk("rst_losses", losses, 0);
        chk("rst_reject", reject, 0);
        chk("rst_auto", auto_move, 0);
        chk("rst_state", 32'(dut.state_q), 0);
        reset_n = 1'b1;
        tick();

        // Bouncing press with move 3, then acknowledge.
        game_ready = 1'b1; move_sw = 3'd3;
        tick();
        chk("armed_state", 32'(dut.state_q), 1);
        btn = 1'b1; tick(); btn = 1'b0; tick(); btn = 1'b1; tick();
        wait_enter();
        chk("drive_move", move, 3);
        chk("drive_tc", turn_count, 0);
        tick();
        game_ready = 1'b0;
        tick();
        chk("ack_enter", enter, 0);
        chk("ack_tc", turn_count, 1);
        // Press while in RELEASE must be dropped, not queued.
        btn = 1'b0; tick(8);
        btn = 1'b1; tick(8);
        btn = 1'b0; tick(8);
        game_ready = 1'b1; tick(3);
        chk("no_queue_state", 32'(dut.state_q), 1);
        chk("one_drive", enter_rises, 1);

        // Press with ready stuck high: 8 cycles of enter, reject, no count.
        move_sw = 3'd2; en_hi = 0; rej_cnt = 0; btn = 1'b1;
        tick(25);
        chk("noack_en_hi", en_hi, 8);
        chk("noack_reject", rej_cnt, 1);
        chk("noack_tc", turn_count, 1);
        chk("noack_move", move, 2);
        btn = 1'b0; tick(8);

        // Illegal moves are refused in ARMED.
        foreach (bad_mv[k]) begin
            move_sw = bad_mv[k]; rej_cnt = 0; btn = 1'b1;
            tick(10);
            chk("bad_reject", rej_cnt, 1);
            chk("bad_state", 32'(dut.state_q), 1);
            btn = 1'b0; tick(8);
        end
        chk("bad_move_held", move, 2);
        chk("bad_no_enter", enter_rises, 2);

        // Reach turn_count 4 using boundary moves, then a win.
        do_turn(3'd5); do_turn(3'd1); do_turn(3'd4);
        chk("tc_four", turn_count, 4);
        chk("last_move", move, 4);
        game_lostwon = 1'b1; game_gameover = 1'b1;
        tick();
        chk("win_one", wins, 1);
        chk("win_tc_clr", turn_count, 0);
        game_gameover = 1'b0; tick();
        for (int i = 0; i < 15; i++) begin
            game_gameover = 1'b1; tick();
            game_gameover = 1'b0; tick();
        end
        chk("wins_sat", wins, 15);
        chk("losses_zero", losses, 0);

        // Game-over and acknowledge in the same cycle: clear wins.
        do_turn(3'd2);
        chk("tc_one_again", turn_count, 1);
        move_sw = 3'd4; btn = 1'b1;
        wait_enter();
        game_ready = 1'b0; game_gameover = 1'b1; game_lostwon = 1'b0;
        tick();
        chk("prio_tc", turn_count, 0);
        chk("prio_loss", losses, 1);
        game_gameover = 1'b0; btn = 1'b0; game_ready = 1'b1;
        tick(8);

        // turn_count saturates at 31.
        for (int i = 0; i < 32; i++) do_turn(3'd1);
        chk("tc_sat", turn_count, 31);

        // Async reset in the middle of DRIVE.
        move_sw = 3'd3; btn = 1'b1;
        wait_enter();
        #2 reset_n = 1'b0;
        #1 chk("async_enter", enter, 0);
        btn = 1'b0; game_ready = 1'b0;
        #10 reset_n = 1'b1;
        tick(2);
        chk("post_rst_out", {enter, move, turn_count, wins, losses, reject, auto_move}, 0);
        chk("post_rst_state", 32'(dut.state_q), 0);

`ifdef TURN_TIMEOUT_EN
        begin
            int n;
            game_ready = 1'b1;
            tick();
            n = 0;
            while (!auto_move && n < 40) begin
                tick();
                n++;
            end
            chk("tmo_cycles", n, 20);
            chk("tmo_enter", enter, 1);
            chk("tmo_move", move, 1);
            tick();
            chk("tmo_pulse", auto_move, 0);
        end
`else
        tick(3);
        chk("auto_tied", auto_move, 0);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
